// File: rtl/cdda_mixer.sv
// CDDA output stage: 44.1 kHz strobe, ramped CDDA gain, optional de-emphasis, core mix and 16-bit saturation.
// Build option: define CDDA_DEEMPH_EN to include the per-channel one-pole de-emphasis filter.
//
// state  | meaning
// S_IDLE | gain equals target, no ramp in progress
// S_UP   | gain stepping +1 per strobe toward target
// S_DOWN | gain stepping -1 per strobe toward target
module cdda_mixer #(
    parameter int CLK_HZ = 42000000,
    parameter int FS_HZ  = 44100
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    output logic        cen_44100,
    input  logic [15:0] cdda_l,
    input  logic [15:0] cdda_r,
    input  logic [15:0] core_l,
    input  logic [15:0] core_r,
    input  logic [7:0]  cdda_vol,
    input  logic        mute,
    input  logic        deemph,
    output logic        fade_busy,
    output logic [15:0] mix_l,
    output logic [15:0] mix_r
);

    typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} ramp_state_t;

    localparam logic [31:0] FS_INC  = 32'(FS_HZ);
    localparam logic [31:0] CLK_MOD = 32'(CLK_HZ);

    ramp_state_t        state;
    logic [31:0]        acc;
    logic [31:0]        acc_next;
    logic [8:0]         gain;
    logic [8:0]         target;
    logic               v1, v2, v3;
    logic signed [15:0] samp_l, samp_r, core_sl, core_sr;
    logic signed [24:0] prod_l, prod_r;
    logic signed [16:0] g_l, g_r, y_l, y_r;
    logic signed [17:0] sum_l, sum_r;

    // Fractional divider: long-run strobe rate is exactly FS_HZ/CLK_HZ
    assign acc_next = acc + FS_INC;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            cen_44100 <= 1'b0;
        end else if (acc_next >= CLK_MOD) begin
            acc       <= acc_next - CLK_MOD;
            cen_44100 <= 1'b1;
        end else begin
            acc       <= acc_next;
            cen_44100 <= 1'b0;
        end
    end

    assign target = mute ? 9'd0 : (cdda_vol == 8'hFF) ? 9'd256 : {1'b0, cdda_vol};

    // A target reversal costs one strobe without a step before ramping the other way
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            gain      <= '0;
            fade_busy <= 1'b0;
        end else if (cen_44100) begin
            case (state)
                S_IDLE: begin
                    if (gain < target) begin
                        state     <= S_UP;
                        fade_busy <= 1'b1;
                    end else if (gain > target) begin
                        state     <= S_DOWN;
                        fade_busy <= 1'b1;
                    end
                end
                S_UP: begin
                    if (target < gain) begin
                        state <= S_DOWN;
                    end else if (target == gain) begin
                        state     <= S_IDLE;
                        fade_busy <= 1'b0;
                    end else begin
                        gain <= gain + 9'd1;
                        if (gain + 9'd1 == target) begin
                            state     <= S_IDLE;
                            fade_busy <= 1'b0;
                        end
                    end
                end
                S_DOWN: begin
                    if (target > gain) begin
                        state <= S_UP;
                    end else if (target == gain) begin
                        state     <= S_IDLE;
                        fade_busy <= 1'b0;
                    end else begin
                        gain <= gain - 9'd1;
                        if (gain - 9'd1 == target) begin
                            state     <= S_IDLE;
                            fade_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    fade_busy <= 1'b0;
                end
            endcase
        end
    end

    assign prod_l = $signed({{9{samp_l[15]}}, samp_l}) * $signed({16'd0, gain});
    assign prod_r = $signed({{9{samp_r[15]}}, samp_r}) * $signed({16'd0, gain});
    assign sum_l  = {y_l[16], y_l} + {{2{core_sl[15]}}, core_sl};
    assign sum_r  = {y_r[16], y_r} + {{2{core_sr[15]}}, core_sr};

    function automatic logic [15:0] sat16(input logic signed [17:0] s);
        if (s > 18'sd32767)
            return 16'h7FFF;
        else if (s < -18'sd32768)
            return 16'h8000;
        else
            return s[15:0];
    endfunction

`ifdef CDDA_DEEMPH_EN
    logic signed [17:0] d_l, d_r;
    assign d_l = {g_l[16], g_l} - {y_l[16], y_l};
    assign d_r = {g_r[16], g_r} - {y_r[16], y_r};
`else
    logic deemph_unused;
    assign deemph_unused = deemph;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            {v1, v2, v3} <= '0;
            samp_l  <= '0;
            samp_r  <= '0;
            core_sl <= '0;
            core_sr <= '0;
            g_l     <= '0;
            g_r     <= '0;
            y_l     <= '0;
            y_r     <= '0;
            mix_l   <= '0;
            mix_r   <= '0;
        end else begin
            v1 <= cen_44100;
            v2 <= v1;
            v3 <= v2;
            if (cen_44100) begin
                samp_l  <= cdda_l;
                samp_r  <= cdda_r;
                core_sl <= core_l;
                core_sr <= core_r;
            end
            if (v1) begin
                g_l <= 17'(prod_l >>> 8);
                g_r <= 17'(prod_r >>> 8);
            end
            if (v2) begin
`ifdef CDDA_DEEMPH_EN
                y_l <= deemph ? y_l + 17'(d_l >>> 1) : g_l;
                y_r <= deemph ? y_r + 17'(d_r >>> 1) : g_r;
`else
                y_l <= g_l;
                y_r <= g_r;
`endif
            end
            if (v3) begin
                mix_l <= sat16(sum_l);
                mix_r <= sat16(sum_r);
            end
        end
    end

endmodule

// File: tb/tb_cdda_mixer.sv
// Randomized self-checking bench for cdda_mixer against an arithmetic gain/mix model.
// Runs with a 441 kHz system clock so a strobe arrives every 10 clocks.
module tb_cdda_mixer;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cen_44100;
    logic [15:0] cdda_l = '0, cdda_r = '0, core_l = '0, core_r = '0;
    logic [7:0]  cdda_vol = 8'hFF;
    logic        mute = 1'b0;
    logic        deemph = 1'b0;
    logic        fade_busy;
    logic [15:0] mix_l, mix_r;

    int n_checks = 0;
    int n_fail   = 0;

    int m_gain, m_dir, m_yl, m_yr, exp_l, exp_r;
    bit m_busy;

    cdda_mixer #(.CLK_HZ(441000), .FS_HZ(44100)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .cen_44100(cen_44100),
        .cdda_l(cdda_l), .cdda_r(cdda_r), .core_l(core_l), .core_r(core_r),
        .cdda_vol(cdda_vol), .mute(mute), .deemph(deemph),
        .fade_busy(fade_busy), .mix_l(mix_l), .mix_r(mix_r)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        m_gain = 0; m_dir = 0; m_busy = 0; m_yl = 0; m_yr = 0;
    endtask

    // Gain moves one unit per strobe toward the target; a change of direction wastes one strobe
    task automatic model_strobe();
        int tgt, sgn, gl, gr;
        tgt = mute ? 0 : (cdda_vol == 8'hFF) ? 256 : int'(cdda_vol);
        sgn = (tgt > m_gain) ? 1 : (tgt < m_gain) ? -1 : 0;
        if (m_busy && sgn == m_dir) begin
            m_gain += m_dir;
            m_busy = (m_gain != tgt);
        end else begin
            m_busy = (sgn != 0);
            m_dir  = sgn;
        end
        gl = int'($signed(cdda_l)) * m_gain;
        gr = int'($signed(cdda_r)) * m_gain;
        gl = gl >>> 8;
        gr = gr >>> 8;
`ifdef CDDA_DEEMPH_EN
        if (deemph) begin
            m_yl = m_yl + ((gl - m_yl) >>> 1);
            m_yr = m_yr + ((gr - m_yr) >>> 1);
        end else begin
            m_yl = gl;
            m_yr = gr;
        end
`else
        m_yl = gl;
        m_yr = gr;
`endif
        exp_l = clamp16(m_yl + int'($signed(core_l)));
        exp_r = clamp16(m_yr + int'($signed(core_r)));
    endtask

    task automatic run_strobe();
        int n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (cen_44100 !== 1'b1 && n < 40);
        if (cen_44100 !== 1'b1) begin
            check("strobe_timeout", 0, 1);
            return;
        end
        model_strobe();
        repeat (4) @(negedge clk_sys);
        check("mix_l", int'($signed(mix_l)), exp_l);
        check("mix_r", int'($signed(mix_r)), exp_r);
        check("fade_busy", int'(fade_busy), int'(m_busy));
    endtask

    task automatic apply_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        model_reset();
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, first, b2b, busy_cnt, steps;
        bit prev;

        repeat (3) @(negedge clk_sys);
        check("rst_cen", int'(cen_44100), 0);
        check("rst_mix_l", int'(mix_l), 0);
        check("rst_mix_r", int'(mix_r), 0);
        check("rst_busy", int'(fade_busy), 0);

        reset_n = 1'b1;
        cnt = 0; first = -1; b2b = 0; prev = 1'b0;
        for (int k = 1; k <= 4410; k++) begin
            @(negedge clk_sys);
            if (cen_44100) begin
                cnt++;
                if (first < 0) first = k;
                if (prev) b2b++;
            end
            prev = cen_44100;
        end
        check("strobe_count", cnt, 441);
        check("strobe_first", first, 10);
        check("strobe_b2b", b2b, 0);

        // Full fade-in from reset
        cdda_vol = 8'hFF; mute = 1'b0; deemph = 1'b0;
        cdda_l = 16'h4000; cdda_r = 16'(-1234); core_l = '0; core_r = '0;
        apply_reset();
        busy_cnt = 0;
        for (int i = 0; i < 260; i++) begin
            run_strobe();
            if (fade_busy) busy_cnt++;
        end
        check("fadein_busy_strobes", busy_cnt, 256);
        check("fadein_mix_l", int'(mix_l), 16'h4000);
        check("fadein_busy_end", int'(fade_busy), 0);

        // Saturation at unity gain
        cdda_l = 16'h7FFF; core_l = 16'h7FFF; cdda_r = 16'h8000; core_r = 16'h8000;
        run_strobe();
        check("sat_hi", int'(mix_l), 16'h7FFF);
        check("sat_lo", int'(mix_r), 16'h8000);

        // Mute during an up-ramp at gain 100
        cdda_l = 16'h4000; cdda_r = 16'h1000; core_l = '0; core_r = '0;
        apply_reset();
        steps = 0;
        while (m_gain < 100 && steps < 200) begin
            run_strobe();
            steps++;
        end
        mute = 1'b1;
        run_strobe();
        check("mute_hold_mix", int'($signed(mix_l)), 100 * 64);
        check("mute_hold_busy", int'(fade_busy), 1);
        steps = 0;
        while (fade_busy && steps < 200) begin
            run_strobe();
            steps++;
        end
        check("mute_steps", steps, 100);
        check("mute_mix_zero", int'(mix_l), 0);

        // Asynchronous reset mid-ramp
        mute = 1'b0;
        apply_reset();
        for (int i = 0; i < 50; i++) run_strobe();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_mix_l", int'(mix_l), 0);
        check("async_mix_r", int'(mix_r), 0);
        check("async_busy", int'(fade_busy), 0);
        check("async_cen", int'(cen_44100), 0);
        model_reset();
        @(negedge clk_sys);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) run_strobe();
        check("restart_mix", int'($signed(mix_l)), 128);

        // Randomized volume, mute, deemph and sample traffic
        for (int i = 0; i < 400; i++) begin
            cdda_l = 16'($urandom);
            cdda_r = 16'($urandom);
            core_l = 16'($urandom);
            core_r = 16'($urandom);
            deemph = 1'($urandom_range(1));
            if ($urandom_range(7) == 0)
                cdda_vol = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom_range(255));
            if ($urandom_range(9) == 0)
                mute = ~mute;
            run_strobe();
        end

`ifdef CDDA_DEEMPH_EN
        // De-emphasis step response at unity gain
        mute = 1'b0; cdda_vol = 8'hFF; deemph = 1'b0;
        cdda_l = '0; cdda_r = '0; core_l = '0; core_r = '0;
        apply_reset();
        for (int i = 0; i < 258; i++) run_strobe();
        cdda_l = 16'h4000; deemph = 1'b1;
        run_strobe();
        check("deemph_1", int'(mix_l), 16'h2000);
        run_strobe();
        check("deemph_2", int'(mix_l), 16'h3000);
        run_strobe();
        check("deemph_3", int'(mix_l), 16'h3800);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
